// File: rtl/load_hazard_unit_if.sv
// Decode/memory-side signal bundle for the load hazard unit.
// The decode stage drives the instruction fields (master); the hazard unit answers with stalls (slave).
interface load_hazard_unit_if #(
    parameter int NREG = 16,
    parameter int AW   = 4
);
    logic            id_valid;
    logic [AW-1:0]   id_srcA;
    logic [AW-1:0]   id_srcB;
    logic            id_useA;
    logic            id_useB;
    logic [AW-1:0]   id_dest;
    logic            id_we;
    logic            id_isload;
    logic            mem_wait;
    logic            flush;
    logic            stall_if;
    logic            stall_id;
    logic            bubble_ex;
    logic [NREG-1:0] pending;

    modport master (
        output id_valid, id_srcA, id_srcB, id_useA, id_useB,
               id_dest, id_we, id_isload, mem_wait, flush,
        input  stall_if, stall_id, bubble_ex, pending
    );

    modport slave (
        input  id_valid, id_srcA, id_srcB, id_useA, id_useB,
               id_dest, id_we, id_isload, mem_wait, flush,
        output stall_if, stall_id, bubble_ex, pending
    );
endinterface

// File: rtl/load_hazard_unit.sv
// Load-use hazard scoreboard: stalls IF/ID and bubbles EX until an in-flight load is forwardable.
// Optional macro HAZARD_STATS_EN adds a saturating 32-bit count of bubble cycles (stall_count).
module load_hazard_unit #(
    parameter int NREG     = 16,
    parameter int AW       = 4,
    parameter int LOAD_LAT = 2,
    parameter int CW       = 3
) (
    input  logic               clk,
    input  logic               rst,
    load_hazard_unit_if.slave  hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    localparam logic [CW-1:0] LAT_INIT = CW'(LOAD_LAT);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];

    logic [AW-1:0] srcA;
    logic [AW-1:0] srcB;
    logic [AW-1:0] dest;
    logic          hazA;
    logic          hazB;
    logic          stallRaw;
    logic          issue;
    logic          loadIssue;

    // Hazard detection reads the scoreboard before this cycle's update,
    // so an instruction never waits on its own destination.
    always_comb begin
        srcA      = hz.id_srcA;
        srcB      = hz.id_srcB;
        dest      = hz.id_dest;
        hazA      = hz.id_valid & hz.id_useA & (srcA != '0) & (cnt_q[srcA] != '0);
        hazB      = hz.id_valid & hz.id_useB & (srcB != '0) & (cnt_q[srcB] != '0);
        stallRaw  = hazA | hazB;
        issue     = hz.id_valid & ~stallRaw & ~hz.mem_wait & ~hz.flush;
        loadIssue = issue & hz.id_we & hz.id_isload & (dest != '0);

        hz.stall_if  = stallRaw | hz.mem_wait;
        hz.stall_id  = stallRaw | hz.mem_wait;
        hz.bubble_ex = stallRaw & ~hz.mem_wait;
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            hz.pending[i] = (cnt_q[i] != '0);
        end
    end

    // A new load overrides the decrement of its destination (WAW reload).
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (hz.flush) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_d[i] = '0;
            end
        end else if (!hz.mem_wait) begin
            for (int i = 0; i < NREG; i++) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - ONE;
                end
            end
            if (loadIssue) begin
                cnt_d[dest] = LAT_INIT;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q;

    // Survives flush on purpose: it measures lost cycles over the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (hz.bubble_ex && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/load_hazard_unit.md
Name: load_hazard_unit

Overview:
- Producer-side counterpart of the pipeline operand-forwarding path; resolves the hazards that forwarding cannot cover.
- Keeps a per-register scoreboard of in-flight vector/scalar loads whose data is not yet forwardable.
- Stalls the fetch/decode stages and injects a bubble into EX until the value reaches a forwardable stage.
- Sits beside the decode stage and is driven by decoded operand fields and the memory stage.

Parameters:
- NREG, 16, architectural registers; register 0 is hard-wired and never tracked.
- AW, 4, register address width, equal to clog2(NREG).
- LOAD_LAT, 2, cycles after issue before load data is forwardable (1..7).
- CW, 3, scoreboard counter width; must hold LOAD_LAT.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, synchronous active-high reset.
- id_valid, in, 1, decode holds a real instruction.
- id_srcA, in, AW, source register A (R2 field).
- id_srcB, in, AW, source register B (R3 field).
- id_useA, in, 1, instruction reads srcA.
- id_useB, in, 1, instruction reads srcB (0 when B is replaced by an immediate).
- id_dest, in, AW, destination register.
- id_we, in, 1, instruction writes id_dest.
- id_isload, in, 1, instruction is a memory load.
- mem_wait, in, 1, memory stage not ready; the pipeline freezes.
- flush, in, 1, branch/exception squash of all younger in-flight loads.
- stall_if, out, 1, hold the PC and the IF/ID register.
- stall_id, out, 1, hold the decode stage.
- bubble_ex, out, 1, load a NOP into ID/EX.
- pending, out, NREG, bit i = register i has an outstanding load.

Behaviour:
- Scoreboard: cnt[i], CW bits, for i = 1..NREG-1. cnt[0] is constant 0. pending[i] = (cnt[i] != 0).
- hazA = id_valid & id_useA & (id_srcA != 0) & (cnt[id_srcA] != 0). hazB is defined the same way with srcB/useB.
- stall_raw = hazA | hazB. All outputs are combinational from state and inputs:
  - stall_if = stall_id = stall_raw | mem_wait.
  - bubble_ex = stall_raw & ~mem_wait. A frozen pipeline takes no bubble.
- issue = id_valid & ~stall_raw & ~mem_wait & ~flush.
- Per-cycle update, in priority order:
  1. rst: all cnt = 0.
  2. flush: all cnt = 0. An issue in the same cycle is discarded.
  3. mem_wait: all cnt hold. No issue.
  4. Otherwise, every nonzero cnt decrements by 1. Then, if issue & id_we & id_isload & (id_dest != 0), cnt[id_dest] = LOAD_LAT. This overrides the decrement (WAW case).
- Non-load writes never set the scoreboard; forwarding covers them.
- Writes to register 0 are ignored.
- Same-cycle read-after-load: an instruction in decode cannot see its own dest. The check uses cnt before update.
- Latency: a dependent instruction directly behind a load stalls exactly LOAD_LAT cycles (without mem_wait). It issues in the cycle cnt reaches 0.
- Reset values: cnt all 0, pending = 0, stall_if = stall_id = 0 (when mem_wait = 0), bubble_ex = 0.
- Reset mid-stall: stall drops the cycle after rst is sampled.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Adds output stall_count, 32 bits, reset to 0.
  - Increments on every cycle with bubble_ex = 1.
  - Saturates at 32'hFFFF_FFFF.
  - Is not cleared by flush.
- Not defined: the port and counter do not exist. Behaviour is otherwise identical.

Test Plan:
- Load R5 issued (id_isload = 1, id_dest = 5); next cycle an instruction uses srcA = 5 -> stall_if = 1 and bubble_ex = 1 for 2 cycles, then issues; pending[5] = 1 for 2 cycles.
- Load into R0, followed by a reader of R0 -> no stall; pending = 0.
- Load R3, then a consumer with srcB = 3 and id_useB = 0 (immediate) -> no stall. The same consumer with id_useB = 1 -> 2-cycle stall.
- Load R7; mem_wait held for 3 cycles during the stall -> cnt[7] holds, bubble_ex = 0 during the wait, stall_if = 1 throughout. The total stall is 2 + 3 cycles.
- Load R9, then flush in the next cycle -> pending = 0, and the consumer of R9 after the flush issues with no stall.
- Load R4 issued with cnt[4] = 1 from an earlier load -> cnt[4] reloads to 2. With HAZARD_STATS_EN, stall_count equals the total number of bubble cycles across the whole test.
